// File: rtl/bsg_gateway_pkg.sv
// Shared types for the gateway reset sequencer.
package bsg_gateway_pkg;

  // Sequencer states; the encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    REL_TAG   = 3'd2,
    REL_IO    = 3'd3,
    RUN       = 3'd4
  } gw_state_e;

  // Width of the saturating lock-loss debug counter.
  localparam int lock_loss_count_width_lp = 8;

endpackage

// File: rtl/bsg_gateway_reset_seq_if.sv
// Status/control bundle between the reset sequencer and its consumers.
// There is no valid/ready handshake on this bundle: soft_reset is a
// single-cycle request sampled on every clock edge, and tag/io/core reset,
// ready, state and lock_loss_count are registered levels valid every cycle.
interface bsg_gateway_reset_seq_if
  import bsg_gateway_pkg::*;
#(
  parameter int count_width_p = lock_loss_count_width_lp
);
  logic                     locked;
  logic                     soft_reset;
  logic                     tag_reset;
  logic                     io_reset;
  logic                     core_reset;
  logic                     ready;
  logic [2:0]               state;
  logic [count_width_p-1:0] lock_loss_count;

  // Sequencer side.
  modport master (
    input  locked, soft_reset,
    output tag_reset, io_reset, core_reset, ready, state, lock_loss_count
  );

  // Clock block / reset consumer side.
  modport slave (
    output locked, soft_reset,
    input  tag_reset, io_reset, core_reset, ready, state, lock_loss_count
  );
endinterface

// File: rtl/bsg_gateway_sync.sv
// N-stage single-bit flop synchronizer with synchronous active-low reset.
module bsg_gateway_sync #(
  parameter int stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [stages_p-1:0] sync_q, sync_d;

  // Shift the asynchronous input one stage per clock.
  always_comb begin
    sync_d = {sync_q[stages_p-2:0], d_i};
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) sync_q <= '0;
    else            sync_q <= sync_d;
  end

  assign q_o = sync_q[stages_p-1];
endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Gateway reset sequencer: waits for stable lock, then releases the tag, IO
// and core resets in a staggered order; any lock loss or soft reset request
// re-asserts all resets and restarts the sequence.
module bsg_gateway_reset_seq
  import bsg_gateway_pkg::*;
#(
  parameter int lock_stable_cycles_p = 1024,
  parameter int stage_gap_cycles_p   = 256,
  parameter int sync_stages_p        = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                locked_i,
  input  logic                                soft_reset_i,
  output logic                                tag_reset_o,
  output logic                                io_reset_o,
  output logic                                core_reset_o,
  output logic                                ready_o,
  output logic [2:0]                          state_o,
  output logic [lock_loss_count_width_lp-1:0] lock_loss_count_o
);
  localparam int max_cycles_lp = (lock_stable_cycles_p > stage_gap_cycles_p)
                                 ? lock_stable_cycles_p : stage_gap_cycles_p;
  localparam int cnt_w_lp = $clog2(max_cycles_lp) + 1;
  localparam logic [cnt_w_lp-1:0] stable_last_lp = cnt_w_lp'(lock_stable_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] gap_last_lp    = cnt_w_lp'(stage_gap_cycles_p - 1);
  localparam logic [lock_loss_count_width_lp-1:0] loss_max_lp = '1;

  logic                                lock_s;
  logic                                abort;
  logic                                lock_lost;
  gw_state_e                           state_q, state_d;
  logic [cnt_w_lp-1:0]                 cnt_q, cnt_d;
  logic [lock_loss_count_width_lp-1:0] loss_q, loss_d;
  logic [2:0]                          rst_q, rst_d;   // {tag, io, core}
  logic                                ready_q, ready_d;

  bsg_gateway_sync #(
    .stages_p (sync_stages_p)
  ) lock_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (locked_i),
    .q_o       (lock_s)
  );

  // Next-state, shared counter and lock-loss counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loss_d    = loss_q;
    abort     = (state_q != WAIT_LOCK) && (!lock_s || soft_reset_i);
    lock_lost = !lock_s && (state_q inside {REL_TAG, REL_IO, RUN});

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (cnt_q == stable_last_lp) begin
          state_d = REL_TAG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      REL_TAG: begin
        if (cnt_q == gap_last_lp) begin
          state_d = REL_IO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      REL_IO: begin
        if (cnt_q == gap_last_lp) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides any progress made this cycle.
    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end

    if (lock_lost && (loss_q != loss_max_lp)) begin
      loss_d = loss_q + lock_loss_count_width_lp'(1);
    end
  end

  // Decode outputs from the next state so they change on the same edge as state.
  always_comb begin
    rst_d   = 3'b111;
    ready_d = 1'b0;
    case (state_d)
      REL_TAG: rst_d = 3'b011;
      REL_IO:  rst_d = 3'b001;
      RUN: begin
        rst_d   = 3'b000;
        ready_d = 1'b1;
      end
      default: rst_d = 3'b111;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
      rst_q   <= 3'b111;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign tag_reset_o       = rst_q[2];
  assign io_reset_o        = rst_q[1];
  assign core_reset_o      = rst_q[0];
  assign ready_o           = ready_q;
  assign state_o           = state_q;
  assign lock_loss_count_o = loss_q;
endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Bench for the gateway reset sequencer: default-parameter instance for the
// timing scenarios, short-parameter instance for counter saturation.
module tb_bsg_gateway_reset_seq;
  import bsg_gateway_pkg::*;

  localparam int W = 15;  // {state[2:0], tag, io, core, ready, count[7:0]}

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  // Clock and edge counter: at a negedge, cyc equals the number of posedges so far.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_gateway_reset_seq_if gw_if ();
  bsg_gateway_reset_seq_if gw_if_f ();

  bsg_gateway_reset_seq dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .locked_i          (gw_if.locked),
    .soft_reset_i      (gw_if.soft_reset),
    .tag_reset_o       (gw_if.tag_reset),
    .io_reset_o        (gw_if.io_reset),
    .core_reset_o      (gw_if.core_reset),
    .ready_o           (gw_if.ready),
    .state_o           (gw_if.state),
    .lock_loss_count_o (gw_if.lock_loss_count)
  );

  bsg_gateway_reset_seq #(
    .lock_stable_cycles_p (2),
    .stage_gap_cycles_p   (1),
    .sync_stages_p        (2)
  ) dut_f (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .locked_i          (gw_if_f.locked),
    .soft_reset_i      (gw_if_f.soft_reset),
    .tag_reset_o       (gw_if_f.tag_reset),
    .io_reset_o        (gw_if_f.io_reset),
    .core_reset_o      (gw_if_f.core_reset),
    .ready_o           (gw_if_f.ready),
    .state_o           (gw_if_f.state),
    .lock_loss_count_o (gw_if_f.lock_loss_count)
  );

  logic [W-1:0] vec, vec_f;
  assign vec   = {gw_if.state, gw_if.tag_reset, gw_if.io_reset, gw_if.core_reset,
                  gw_if.ready, gw_if.lock_loss_count};
  assign vec_f = {gw_if_f.state, gw_if_f.tag_reset, gw_if_f.io_reset, gw_if_f.core_reset,
                  gw_if_f.ready, gw_if_f.lock_loss_count};

  // rr = {tag, io, core, ready}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [3:0] rr,
                                      input logic [7:0] c);
    return {st, rr, c};
  endfunction

  task automatic push(input logic [W-1:0] v, input int c);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: each output change of the default instance is popped against
  // the next expected value and the edge at which it must appear.
  task automatic sb_drain(input string name);
    logic [W-1:0] prev;
    logic [W-1:0] want;
    int           want_c;
    bit           seen;
    while (exp_q.size() > 0) begin
      prev = vec;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
        @(negedge clk);
        if (vec !== prev) seen = 1'b1;
      end
      want   = exp_q.pop_front();
      want_c = exp_cyc_q.pop_front();
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL %s: no output change, got %h required %h at cycle %0d",
                 name, vec, want, want_c);
      end else begin
        if (vec !== want) begin
          n_fail++;
          $display("FAIL %s value: got %h required %h (cycle %0d)", name, vec, want, cyc);
        end
        n_checks++;
        if (cyc != want_c) begin
          n_fail++;
          $display("FAIL %s timing: change at cycle %0d required cycle %0d", name, cyc, want_c);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n            = 1'b0;
    gw_if.locked       = 1'b0;
    gw_if.soft_reset   = 1'b0;
    gw_if_f.locked     = 1'b0;
    gw_if_f.soft_reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (vec !== mk(3'd0, 4'b1110, 8'd0)) begin
        n_fail++;
        $display("FAIL reset_values: got %h required %h", vec, mk(3'd0, 4'b1110, 8'd0));
      end
      n_checks++;
      if (vec_f !== mk(3'd0, 4'b1110, 8'd0)) begin
        n_fail++;
        $display("FAIL reset_values_fast: got %h required %h", vec_f, mk(3'd0, 4'b1110, 8'd0));
      end
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_power_up();
    int c;
    c = cyc;
    gw_if.locked = 1'b1;
    push(mk(3'd1, 4'b1110, 8'd0), c + 3);
    push(mk(3'd2, 4'b0110, 8'd0), c + 1027);
    push(mk(3'd3, 4'b0010, 8'd0), c + 1283);
    push(mk(3'd4, 4'b0001, 8'd0), c + 1539);
    sb_drain("power_up");
  endtask

  // Soft reset pulse: abort must appear exactly one edge later.
  task automatic soft_pulse(input string name, input logic [7:0] cnt_exp);
    gw_if.soft_reset = 1'b1;
    @(negedge clk);
    gw_if.soft_reset = 1'b0;
    n_checks++;
    if (vec !== mk(3'd0, 4'b1110, cnt_exp)) begin
      n_fail++;
      $display("FAIL %s: got %h required %h one edge after request", name, vec,
               mk(3'd0, 4'b1110, cnt_exp));
    end
  endtask

  task automatic test_glitch_stable();
    int s, d;
    s = cyc;
    soft_pulse("glitch_restart_soft", 8'd0);
    push(mk(3'd1, 4'b1110, 8'd0), s + 2);
    sb_drain("glitch_enter_stable");
    // FSM samples lock_s=0 while its counter holds 500.
    d = s + 500;
    wait_cyc(d);
    gw_if.locked = 1'b0;
    @(negedge clk);
    gw_if.locked = 1'b1;
    push(mk(3'd0, 4'b1110, 8'd0), d + 3);
    push(mk(3'd1, 4'b1110, 8'd0), d + 4);
    push(mk(3'd2, 4'b0110, 8'd0), d + 1028);
    push(mk(3'd3, 4'b0010, 8'd0), d + 1284);
    push(mk(3'd4, 4'b0001, 8'd0), d + 1540);
    sb_drain("glitch_stable");
  endtask

  task automatic test_loss_in_run();
    int f, g;
    f = cyc;
    gw_if.locked = 1'b0;
    push(mk(3'd0, 4'b1110, 8'd1), f + 3);
    sb_drain("loss_in_run");
    wait_cyc(f + 8);
    g = cyc;
    gw_if.locked = 1'b1;
    push(mk(3'd1, 4'b1110, 8'd1), g + 3);
    push(mk(3'd2, 4'b0110, 8'd1), g + 1027);
    push(mk(3'd3, 4'b0010, 8'd1), g + 1283);
    push(mk(3'd4, 4'b0001, 8'd1), g + 1539);
    sb_drain("relock_after_run_loss");
  endtask

  task automatic test_soft_and_loss_rel_io();
    int s, k, g;
    s = cyc;
    soft_pulse("soft_restart", 8'd1);
    push(mk(3'd1, 4'b1110, 8'd1), s + 2);
    push(mk(3'd2, 4'b0110, 8'd1), s + 1026);
    push(mk(3'd3, 4'b0010, 8'd1), s + 1282);
    sb_drain("to_rel_io");
    // Lock loss and soft reset both reach the FSM at edge k.
    k = s + 1382;
    wait_cyc(k - 3);
    gw_if.locked = 1'b0;
    wait_cyc(k - 1);
    gw_if.soft_reset = 1'b1;
    @(negedge clk);
    gw_if.soft_reset = 1'b0;
    n_checks++;
    if (vec !== mk(3'd0, 4'b1110, 8'd2)) begin
      n_fail++;
      $display("FAIL soft_loss_rel_io: got %h required %h", vec, mk(3'd0, 4'b1110, 8'd2));
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (gw_if.lock_loss_count !== 8'd2) begin
      n_fail++;
      $display("FAIL soft_loss_single_count: got %0d required 2", gw_if.lock_loss_count);
    end
    g = cyc;
    gw_if.locked = 1'b1;
    push(mk(3'd1, 4'b1110, 8'd2), g + 3);
    push(mk(3'd2, 4'b0110, 8'd2), g + 1027);
    push(mk(3'd3, 4'b0010, 8'd2), g + 1283);
    push(mk(3'd4, 4'b0001, 8'd2), g + 1539);
    sb_drain("relock_after_rel_io");
    // Soft reset alone in RUN: one-edge abort, count unchanged.
    s = cyc;
    soft_pulse("soft_in_run", 8'd2);
    push(mk(3'd1, 4'b1110, 8'd2), s + 2);
    push(mk(3'd2, 4'b0110, 8'd2), s + 1026);
    sb_drain("soft_in_run_restart");
  endtask

  task automatic test_reset_in_rel_tag();
    int t;
    t = cyc + 50;
    wait_cyc(t);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_checks++;
    if (vec !== mk(3'd0, 4'b1110, 8'd0)) begin
      n_fail++;
      $display("FAIL reset_in_rel_tag: got %h required %h", vec, mk(3'd0, 4'b1110, 8'd0));
    end
    // Synchronizer was cleared, so lock must re-propagate through both stages.
    push(mk(3'd1, 4'b1110, 8'd0), t + 4);
    sb_drain("after_reset_relock");
  endtask

  task automatic test_saturation();
    int  c, expc;
    bit  got;
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      gw_if_f.locked = 1'b1;
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge clk);
        if (gw_if_f.ready === 1'b1) got = 1'b1;
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL sat_ready_timeout: iteration %0d ready %b required 1", i, gw_if_f.ready);
        break;
      end
      if (i == 0) begin
        n_checks++;
        if (cyc != c + 7) begin
          n_fail++;
          $display("FAIL sat_ready_timing: cycle %0d required %0d", cyc, c + 7);
        end
      end
      gw_if_f.locked = 1'b0;
      expc = (i + 1 > 255) ? 255 : i + 1;
      exp_q.push_back(mk(3'd0, 4'b1110, 8'(expc)));
      repeat (3) @(negedge clk);
      n_checks++;
      if (vec_f !== exp_q[0]) begin
        n_fail++;
        $display("FAIL sat_abort iter %0d: got %h required %h", i, vec_f, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    n_checks++;
    if (gw_if_f.lock_loss_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: got %0d required 255", gw_if_f.lock_loss_count);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch_stable();
    test_loss_in_run();
    test_soft_and_loss_rel_io();
    test_reset_in_rel_tag();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
